// File: rtl/tick_stopwatch_pkg.sv
// Shared types and constants for the tick-driven BCD stopwatch.
// The time value is held as packed BCD digit pairs so no binary-to-BCD conversion is needed.
package tick_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    LAP_HOLD = 2'd2,
    PAUSE    = 2'd3
  } sw_state_t;

  typedef struct packed {
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] cs;
  } bcd_time_t;

  localparam logic [7:0]  CS_MAX             = 8'h99;
  localparam logic [7:0]  SEC_MAX            = 8'h59;
  localparam logic [7:0]  MIN_MAX            = 8'h59;
  localparam logic [15:0] WDOG_LIMIT_DEFAULT = 16'd8192;

  // Two-digit BCD increment; bit 8 is the carry out when the field wraps from max_val to 00.
  function automatic logic [8:0] bcd2_inc(input logic [7:0] val, input logic [7:0] max_val);
    logic [8:0] res;
    if (val == max_val)
      res = 9'h100;
    else if (val[3:0] == 4'd9)
      res = {1'b0, val[7:4] + 4'd1, 4'd0};
    else
      res = {1'b0, val[7:4], val[3:0] + 4'd1};
    return res;
  endfunction

endpackage

// File: rtl/tick_stopwatch_if.sv
// Command and display bundle between the stopwatch and its controller/display side.
interface tick_stopwatch_if;
  logic       START_STOP;
  logic       LAP;
  logic       CLEAR;
  logic [7:0] CS_BCD;
  logic [7:0] SEC_BCD;
  logic [7:0] MIN_BCD;
  logic       RUNNING;
  logic       LAP_VALID;
  logic       BLINK;
  logic       OVF;
  logic       CLK_FAULT;

  modport master (
    output START_STOP, LAP, CLEAR,
    input  CS_BCD, SEC_BCD, MIN_BCD, RUNNING, LAP_VALID, BLINK, OVF, CLK_FAULT
  );

  modport slave (
    input  START_STOP, LAP, CLEAR,
    output CS_BCD, SEC_BCD, MIN_BCD, RUNNING, LAP_VALID, BLINK, OVF, CLK_FAULT
  );
endinterface

// File: rtl/tick_stopwatch_sync_rise.sv
// Multi-flop synchronizer for a slow asynchronous clock, followed by a one-cycle rising-edge pulse.
module sync_rise #(
  parameter int SYNC_STAGES = 2
) (
  input  logic MCLK,
  input  logic RESET_N,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   prev_reg;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign sync_next[gi] = async_in;
    end else begin : g_rest
      assign sync_next[gi] = sync_reg[gi-1];
    end
  end

  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/tick_stopwatch.sv
// MM:SS.cc BCD stopwatch driven by the synchronized 100 Hz tick, with lap hold, pause blink
// and a sticky stall detector on the tick input.
module tick_stopwatch
  import tick_stopwatch_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter int                WDOG_W      = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT  = WDOG_W'(WDOG_LIMIT_DEFAULT)
) (
  input  logic              MCLK,
  input  logic              RESET_N,
  input  logic              TICK_IN,
  input  logic              SEC_IN,
  tick_stopwatch_if.slave   sw
);

  logic tick_rise;
  logic sec_rise;

  sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
    .MCLK    (MCLK),
    .RESET_N (RESET_N),
    .async_in(TICK_IN),
    .rise    (tick_rise)
  );

  sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sec_sync (
    .MCLK    (MCLK),
    .RESET_N (RESET_N),
    .async_in(SEC_IN),
    .rise    (sec_rise)
  );

  sw_state_t   state_reg, state_next;
  bcd_time_t   count_reg, count_next, count_inc;
  bcd_time_t   snap_reg, snap_next;
  bcd_time_t   disp_reg, disp_next;
  logic        running_reg, lap_valid_reg;
  logic        blink_reg, blink_next;
  logic        ovf_reg, ovf_next;
  logic        fault_reg, fault_next;
  logic [WDOG_W-1:0] wdog_reg, wdog_next;
  logic [8:0]  cs_inc, sec_inc, min_inc;
  logic        wrap;

  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      snap_reg      <= '0;
      disp_reg      <= '0;
      running_reg   <= 1'b0;
      lap_valid_reg <= 1'b0;
      blink_reg     <= 1'b1;
      ovf_reg       <= 1'b0;
      fault_reg     <= 1'b0;
      wdog_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      snap_reg      <= snap_next;
      disp_reg      <= disp_next;
      running_reg   <= (state_next == RUN) || (state_next == LAP_HOLD);
      lap_valid_reg <= (state_next == LAP_HOLD);
      blink_reg     <= blink_next;
      ovf_reg       <= ovf_next;
      fault_reg     <= fault_next;
      wdog_reg      <= wdog_next;
    end
  end

  always_comb begin
    // Carry cascade: each field advances only when every lower field wraps.
    cs_inc    = bcd2_inc(count_reg.cs,  CS_MAX);
    sec_inc   = bcd2_inc(count_reg.sec, SEC_MAX);
    min_inc   = bcd2_inc(count_reg.min, MIN_MAX);
    count_inc = count_reg;
    count_inc.cs = cs_inc[7:0];
    if (cs_inc[8])
      count_inc.sec = sec_inc[7:0];
    if (cs_inc[8] && sec_inc[8])
      count_inc.min = min_inc[7:0];
    wrap = cs_inc[8] & sec_inc[8] & min_inc[8];

    state_next = state_reg;
    count_next = count_reg;
    snap_next  = snap_reg;
    ovf_next   = 1'b0;

    if (tick_rise && (state_reg == RUN || state_reg == LAP_HOLD)) begin
      count_next = count_inc;
      ovf_next   = wrap;
    end

    // Commands are resolved CLEAR > START_STOP > LAP, each only where it applies.
    case (state_reg)
      IDLE: begin
        if (sw.START_STOP)
          state_next = RUN;
      end
      RUN: begin
        if (sw.START_STOP)
          state_next = PAUSE;
        else if (sw.LAP) begin
          state_next = LAP_HOLD;
          snap_next  = count_reg;
        end
      end
      LAP_HOLD: begin
        if (sw.START_STOP)
          state_next = PAUSE;
        else if (sw.LAP)
          state_next = RUN;
      end
      PAUSE: begin
        if (sw.CLEAR) begin
          state_next = IDLE;
          count_next = '0;
        end else if (sw.START_STOP)
          state_next = RUN;
      end
      default: state_next = IDLE;
    endcase

    disp_next = (state_next == LAP_HOLD) ? snap_next : count_next;

    if (state_next != PAUSE || state_reg != PAUSE)
      blink_next = 1'b1;
    else if (sec_rise)
      blink_next = ~blink_reg;
    else
      blink_next = blink_reg;

    if (tick_rise)
      wdog_next = '0;
    else if (wdog_reg == WDOG_LIMIT)
      wdog_next = wdog_reg;
    else
      wdog_next = wdog_reg + WDOG_W'(1);
    fault_next = fault_reg | (wdog_next == WDOG_LIMIT);
  end

  assign sw.CS_BCD    = disp_reg.cs;
  assign sw.SEC_BCD   = disp_reg.sec;
  assign sw.MIN_BCD   = disp_reg.min;
  assign sw.RUNNING   = running_reg;
  assign sw.LAP_VALID = lap_valid_reg;
  assign sw.BLINK     = blink_reg;
  assign sw.OVF       = ovf_reg;
  assign sw.CLK_FAULT = fault_reg;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: directed scenarios plus random commands, checked every cycle against
// a model that keeps time as a plain centisecond count.
module tb_tick_stopwatch;

  localparam int SS    = 2;
  localparam int LIMIT = 8192;
  localparam int WRAP  = 360000;

  logic MCLK = 1'b0;
  logic RESET_N, TICK_IN, SEC_IN;

  tick_stopwatch_if sw_if ();

  tick_stopwatch #(
    .SYNC_STAGES(SS),
    .WDOG_W     (16),
    .WDOG_LIMIT (16'd8192)
  ) dut (
    .MCLK   (MCLK),
    .RESET_N(RESET_N),
    .TICK_IN(TICK_IN),
    .SEC_IN (SEC_IN),
    .sw     (sw_if)
  );

  always #10 MCLK = ~MCLK;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model
  typedef enum int {M_IDLE, M_RUN, M_LAP, M_PAUSE} mmode_t;
  mmode_t m_mode;
  int     m_live, m_snap, m_idle;
  bit     m_blink, m_ovf, m_fault;
  bit     tick_q[$];
  bit     sec_q[$];

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [31:0] model_outs();
    int d;
    d = (m_mode == M_LAP) ? m_snap : m_live;
    return {3'b0, to_bcd(d / 6000), to_bcd((d / 100) % 60), to_bcd(d % 100),
            (m_mode == M_RUN || m_mode == M_LAP), (m_mode == M_LAP), m_blink, m_ovf, m_fault};
  endfunction

  function automatic logic [31:0] dut_outs();
    return {3'b0, sw_if.MIN_BCD, sw_if.SEC_BCD, sw_if.CS_BCD, sw_if.RUNNING,
            sw_if.LAP_VALID, sw_if.BLINK, sw_if.OVF, sw_if.CLK_FAULT};
  endfunction

  function automatic logic [31:0] dut_time();
    return {8'h0, sw_if.MIN_BCD, sw_if.SEC_BCD, sw_if.CS_BCD};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_live = 0; m_snap = 0; m_idle = 0;
    m_blink = 1'b1; m_ovf = 1'b0; m_fault = 1'b0;
    tick_q = {};
    sec_q  = {};
    for (int i = 0; i < SS + 2; i++) begin
      tick_q.push_back(1'b0);
      sec_q.push_back(1'b0);
    end
  endtask

  // Advance the model by one MCLK edge using the inputs present at that edge.
  task automatic model_edge();
    bit tr, sr;
    mmode_t old_mode;
    if (!RESET_N) begin
      model_reset();
      return;
    end
    tick_q.push_back(TICK_IN); void'(tick_q.pop_front());
    sec_q.push_back(SEC_IN);   void'(sec_q.pop_front());
    tr = tick_q[1] && !tick_q[0];
    sr = sec_q[1] && !sec_q[0];
    old_mode = m_mode;
    m_ovf = 1'b0;
    if (old_mode == M_PAUSE && sw_if.CLEAR) begin
      m_mode = M_IDLE;
      m_live = 0;
    end else if (sw_if.START_STOP) begin
      m_mode = (old_mode == M_IDLE || old_mode == M_PAUSE) ? M_RUN : M_PAUSE;
    end else if (sw_if.LAP && old_mode == M_RUN) begin
      m_mode = M_LAP;
      m_snap = m_live;
    end else if (sw_if.LAP && old_mode == M_LAP) begin
      m_mode = M_RUN;
    end
    if ((old_mode == M_RUN || old_mode == M_LAP) && tr) begin
      m_live = m_live + 1;
      if (m_live == WRAP) begin
        m_live = 0;
        m_ovf  = 1'b1;
      end
    end
    if (m_mode != M_PAUSE || old_mode != M_PAUSE) m_blink = 1'b1;
    else if (sr)                                  m_blink = ~m_blink;
    if (tr)                 m_idle = 0;
    else if (m_idle < LIMIT) m_idle = m_idle + 1;
    if (m_idle == LIMIT) m_fault = 1'b1;
  endtask

  task automatic step(input bit do_chk);
    @(posedge MCLK);
    model_edge();
    #1;
    sw_if.START_STOP = 1'b0;
    sw_if.LAP        = 1'b0;
    sw_if.CLEAR      = 1'b0;
    if (do_chk) chk("outs", dut_outs(), model_outs());
  endtask

  task automatic run_ticks(input int n, input bit do_chk);
    for (int i = 0; i < n; i++) begin
      TICK_IN = 1'b1; step(do_chk);
      TICK_IN = 1'b0; step(do_chk);
    end
    repeat (SS + 1) step(do_chk);
  endtask

  initial begin
    bit seen99, seen100, seen6000;
    int guard;
    RESET_N = 1'b0; TICK_IN = 1'b0; SEC_IN = 1'b0;
    sw_if.START_STOP = 1'b0; sw_if.LAP = 1'b0; sw_if.CLEAR = 1'b0;
    model_reset();

    // Reset and tick-to-count latency
    repeat (3) step(1);
    chk("rst_outs", dut_outs(), 32'h4);
    RESET_N = 1'b1; step(1);
    sw_if.START_STOP = 1'b1; step(1);
    chk("start_running", {31'b0, sw_if.RUNNING}, 32'd1);
    TICK_IN = 1'b1; step(1); step(1);
    chk("lat_pre", {24'b0, sw_if.CS_BCD}, 32'h00);
    step(1);
    chk("lat_cs", {24'b0, sw_if.CS_BCD}, 32'h01);
    TICK_IN = 1'b0; step(1);

    // BCD cascade to one minute
    seen99 = 0; seen100 = 0; seen6000 = 0;
    guard = 0;
    while (!seen6000 && guard < 20000) begin
      TICK_IN = ~TICK_IN;
      step(1);
      guard++;
      if (m_live == 99 && !seen99) begin
        seen99 = 1; chk("cs99", dut_time(), 32'h000099);
      end
      if (m_live == 100 && !seen100) begin
        seen100 = 1; chk("cs100", dut_time(), 32'h000100);
      end
      if (m_live == 6000 && !seen6000) begin
        seen6000 = 1; chk("min1", dut_time(), 32'h010000);
      end
    end
    chk("cascade_done", {31'b0, seen6000}, 32'd1);
    TICK_IN = 1'b0;
    repeat (SS + 1) step(1);

    // Long run up to 59:59.99, then the wrap
    run_ticks(WRAP - 1 - m_live, 1'b0);
    chk("pre_wrap", dut_time(), 32'h595999);
    chk("pre_wrap_outs", dut_outs(), model_outs());
    TICK_IN = 1'b1; step(1);
    TICK_IN = 1'b0;
    guard = 0;
    while (!m_ovf && guard < 8) begin
      step(1);
      guard++;
    end
    chk("ovf_hi", {31'b0, sw_if.OVF}, 32'd1);
    chk("wrap_time", dut_time(), 32'h000000);
    chk("wrap_running", {31'b0, sw_if.RUNNING}, 32'd1);
    step(1);
    chk("ovf_lo", {31'b0, sw_if.OVF}, 32'd0);

    // Lap hold and release
    run_ticks(325, 1'b1);
    chk("lap_at", dut_time(), 32'h000325);
    sw_if.LAP = 1'b1; step(1);
    run_ticks(50, 1'b1);
    chk("lap_hold", dut_time(), 32'h000325);
    chk("lap_valid", {31'b0, sw_if.LAP_VALID}, 32'd1);
    sw_if.LAP = 1'b1; step(1);
    chk("lap_live", dut_time(), 32'h000375);
    chk("lap_valid_lo", {31'b0, sw_if.LAP_VALID}, 32'd0);

    // Pause, blink, clear priority
    sw_if.CLEAR = 1'b1; step(1);
    chk("clr_in_run", dut_time(), 32'h000375);
    sw_if.START_STOP = 1'b1; step(1);
    chk("pause_running", {31'b0, sw_if.RUNNING}, 32'd0);
    chk("pause_blink", {31'b0, sw_if.BLINK}, 32'd1);
    run_ticks(5, 1'b1);
    chk("pause_frozen", dut_time(), 32'h000375);
    SEC_IN = 1'b1; repeat (SS + 2) step(1);
    chk("blink_t1", {31'b0, sw_if.BLINK}, 32'd0);
    SEC_IN = 1'b0; repeat (2) step(1);
    SEC_IN = 1'b1; repeat (SS + 2) step(1);
    chk("blink_t2", {31'b0, sw_if.BLINK}, 32'd1);
    SEC_IN = 1'b0; step(1);
    sw_if.CLEAR = 1'b1; sw_if.START_STOP = 1'b1; step(1);
    chk("clr_ss_time", dut_time(), 32'h000000);
    chk("clr_ss_running", {31'b0, sw_if.RUNNING}, 32'd0);
    run_ticks(3, 1'b1);
    chk("idle_frozen", dut_time(), 32'h000000);

    // Random commands, ticks and occasional reset
    for (int i = 0; i < 4000; i++) begin
      TICK_IN = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) SEC_IN = ~SEC_IN;
      sw_if.START_STOP = ($urandom_range(0, 11) == 0);
      sw_if.LAP        = ($urandom_range(0, 11) == 0);
      sw_if.CLEAR      = ($urandom_range(0, 11) == 0);
      RESET_N          = ($urandom_range(0, 999) != 0);
      if (sw_if.START_STOP || sw_if.LAP || sw_if.CLEAR || !RESET_N)
        $display("txn cyc=%0d ss=%0b lap=%0b clr=%0b rst_n=%0b live=%0d",
                 i, sw_if.START_STOP, sw_if.LAP, sw_if.CLEAR, RESET_N, m_live);
      step(1);
      RESET_N = 1'b1;
    end
    TICK_IN = 1'b0; SEC_IN = 1'b0;

    // Watchdog
    RESET_N = 1'b0; step(1);
    RESET_N = 1'b1;
    sw_if.START_STOP = 1'b1; step(1);
    run_ticks(3, 1'b1);
    guard = 0;
    while (m_idle < LIMIT - 1 && guard < 9000) begin
      step(1);
      guard++;
    end
    chk("wd_pre", {31'b0, sw_if.CLK_FAULT}, 32'd0);
    step(1);
    chk("wd_hit", {31'b0, sw_if.CLK_FAULT}, 32'd1);
    run_ticks(5, 1'b1);
    chk("wd_sticky", {31'b0, sw_if.CLK_FAULT}, 32'd1);
    chk("wd_counting", {31'b0, sw_if.RUNNING}, 32'd1);
    RESET_N = 1'b0; step(1);
    chk("wd_rst", {31'b0, sw_if.CLK_FAULT}, 32'd0);
    RESET_N = 1'b1; step(1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch.md
Name: tick_stopwatch

Overview:
- Consumer end of the divided-clock interface: samples the slow generated clocks (100 Hz tick, 1 Hz second) in the MCLK domain.
- Turns their rising edges into single-cycle enables and drives a BCD stopwatch (MM:SS.cc) with start/stop, lap-hold and clear.
- Watches the tick for stalls.
- Sits between the clock generator and the display/segment driver.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per slow-clock input (min 2).
- WDOG_LIMIT, 16'd8192, MCLK cycles without a TICK_IN rising edge before CLK_FAULT asserts.
- WDOG_W, 16, watchdog counter width.

Ports:
- MCLK  in  1  system clock (50 MHz).
- RESET_N  in  1  synchronous, active-low reset; sampled on posedge MCLK.
- TICK_IN  in  1  100 Hz divided clock, asynchronous to MCLK phase.
- SEC_IN  in  1  1 Hz divided clock, asynchronous to MCLK phase.
- START_STOP  in  1  one-MCLK-cycle command pulse, already debounced.
- LAP  in  1  one-cycle command pulse.
- CLEAR  in  1  one-cycle command pulse.
- CS_BCD  out  8  centiseconds, two BCD digits, 00-99.
- SEC_BCD  out  8  seconds, two BCD digits, 00-59.
- MIN_BCD  out  8  minutes, two BCD digits, 00-59.
- RUNNING  out  1  high in RUN or LAP_HOLD.
- LAP_VALID  out  1  high while the displayed value is a lap snapshot.
- BLINK  out  1  display blink enable.
- OVF  out  1  one-cycle pulse on 59:59.99 -> 00:00.00 wrap.
- CLK_FAULT  out  1  sticky tick-stall flag.

Behaviour:
- Reset (RESET_N=0 at posedge MCLK): state=IDLE; live count, snapshot and all BCD outputs = 0; RUNNING=0, LAP_VALID=0, BLINK=1, OVF=0, CLK_FAULT=0; synchronizer, edge registers and watchdog cleared.
- Reset mid-count: everything zeroes on that edge. No pending command survives reset.
- Edge detect:
  - Each slow input passes SYNC_STAGES flops, then one edge register; rise = sync & ~prev, one cycle wide.
  - TICK_IN rise to count update latency: SYNC_STAGES+1 MCLK cycles.
- Count, on tick_rise in RUN or LAP_HOLD:
  - cs+1. At cs=99: cs=0, sec+1. At sec=59 with carry: sec=0, min+1. At min=59 with carry: min=0 and OVF=1 for one cycle; counting continues.
  - Pure BCD arithmetic. Each digit wraps 9->0 with carry; no binary-to-BCD conversion.
- FSM states: IDLE, RUN, LAP_HOLD, PAUSE.
  - IDLE: count held at 0. START_STOP -> RUN. LAP and CLEAR ignored.
  - RUN: counts. START_STOP -> PAUSE. LAP -> LAP_HOLD, snapshot := registered count of that cycle (pre-increment if tick_rise coincides). CLEAR ignored.
  - LAP_HOLD: live count keeps running; outputs show snapshot; LAP_VALID=1. LAP -> RUN (outputs return to live). START_STOP -> PAUSE (outputs return to live). CLEAR ignored.
  - PAUSE: count frozen; a tick_rise in PAUSE is dropped. START_STOP -> RUN. CLEAR -> IDLE, count := 0. LAP ignored.
- Simultaneous commands: priority CLEAR > START_STOP > LAP. Only the highest applicable command acts; a lower command made irrelevant by the chosen transition is discarded.
- Outputs registered; state change is visible on outputs the cycle after the command pulse.
- BLINK: 1 outside PAUSE. Forced 1 on entry to PAUSE. Toggles on each sec_rise while in PAUSE.
- Watchdog:
  - Counts MCLK cycles in all states; zeroed on tick_rise.
  - Saturates at WDOG_LIMIT; when it reaches WDOG_LIMIT, CLK_FAULT=1.
  - CLK_FAULT is sticky until RESET_N. Later ticks do not clear it.
  - Counting is not blocked by a fault.

Decomposition:
- Package tick_stopwatch_pkg holds:
  - FSM state enum (IDLE, RUN, LAP_HOLD, PAUSE).
  - BCD limit constants CS_MAX=8'h99, SEC_MAX=8'h59, MIN_MAX=8'h59.
  - Default WDOG_LIMIT.
- One sub-module, sync_rise: parameterised SYNC_STAGES synchronizer plus rising-edge pulse. Instantiated twice (TICK_IN, SEC_IN).
- The BCD cascade and FSM stay in the top module.

Test Plan:
- Reset/latency: drive RESET_N low, then START_STOP, then TICK_IN rise. All outputs 0 and BLINK=1 after reset; CS_BCD=8'h01 exactly SYNC_STAGES+1 cycles after the rise.
- BCD cascade: run 6000 ticks from 0. At tick 99 CS=99; at tick 100 CS=00, SEC=01; at tick 6000 MIN=01, SEC=00, CS=00.
- Wrap: preload via ticks to 59:59.99, then one tick. Outputs 00:00.00, OVF high exactly one cycle, RUNNING stays 1.
- Lap: at 00:03.25 pulse LAP, then 50 ticks. Outputs hold 00:03.25 with LAP_VALID=1. Pulse LAP again: outputs 00:03.75, LAP_VALID=0.
- Pause/clear/priority:
  - In RUN, pulse CLEAR: ignored.
  - Pulse START_STOP: PAUSE; ticks do not change count; BLINK toggles per SEC_IN rise.
  - Pulse CLEAR and START_STOP in the same cycle: IDLE with 00:00.00.
- Watchdog: stop TICK_IN toggling in RUN. CLK_FAULT rises after 8192 cycles. Restarting ticks does not clear it; RESET_N low clears it.
